// File: rtl/shift_seq_pkg.sv
// Shared opcode and FSM state encodings for the shift-register sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_SHL   = 2'b01,
    OP_SHR   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_SHIFT = 3'd3,
    S_FIN   = 3'd4
  } state_e;

  function automatic logic is_shift(input logic [1:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter with zero flag; saturates at zero instead of wrapping.
module shift_seq_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving load/clear/shift strobes of a bidirectional shift register.
//   state   | meaning
//   S_IDLE  | waiting for a command handshake
//   S_LOAD  | parallel-load strobe active
//   S_CLEAR | clear strobe active
//   S_SHIFT | shift strobes active, one fill bit per cycle
//   S_FIN   | done pulse, returns to idle
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             reg_clr_n,
  output logic             reg_load,
  output logic             reg_ls,
  output logic             reg_rs,
  output logic [WIDTH-1:0] reg_d,
  output logic             busy,
  output logic             done
);

  state_e           state;
  logic             dir_r;
  logic [WIDTH-1:0] fill_q;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;

  assign cmd_ready = (state == S_IDLE) && clr;

  // Counter holds remaining shifts after the current one, so n-1 is loaded.
  assign cnt_load = cmd_ready && cmd_valid && is_shift(cmd_op) && (cmd_cnt != '0);
  assign cnt_dec  = (state == S_SHIFT) && !cnt_zero;

  shift_seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cmd_cnt - CNT_W'(1)),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_IDLE;
      reg_clr_n <= 1'b1;
      reg_load  <= 1'b0;
      reg_ls    <= 1'b0;
      reg_rs    <= 1'b0;
      reg_d     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dir_r     <= 1'b0;
      fill_q    <= '0;
    end else begin
      reg_clr_n <= 1'b1;
      reg_load  <= 1'b0;
      reg_ls    <= 1'b0;
      reg_rs    <= 1'b0;
      reg_d     <= '0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            busy <= 1'b1;
            case (op_e'(cmd_op))
              OP_LOAD: begin
                state    <= S_LOAD;
                reg_load <= 1'b1;
                reg_d    <= cmd_data;
              end
              OP_CLEAR: begin
                state     <= S_CLEAR;
                reg_clr_n <= 1'b0;
              end
              default: begin
                if (cmd_cnt == '0) begin
                  state <= S_FIN;
                  done  <= 1'b1;
                end else begin
                  state  <= S_SHIFT;
                  dir_r  <= (cmd_op == OP_SHR);
                  fill_q <= cmd_data >> 1;
                  if (cmd_op == OP_SHR) begin
                    reg_rs           <= 1'b1;
                    reg_d[WIDTH-1]   <= cmd_data[0];
                  end else begin
                    reg_ls   <= 1'b1;
                    reg_d[0] <= cmd_data[0];
                  end
                end
              end
            endcase
          end
        end
        S_LOAD, S_CLEAR: begin
          state <= S_FIN;
          done  <= 1'b1;
        end
        S_SHIFT: begin
          if (cnt_zero) begin
            state <= S_FIN;
            done  <= 1'b1;
          end else begin
            // Fill bits run out after WIDTH shifts; zeros shift in from then on.
            fill_q <= fill_q >> 1;
            if (dir_r) begin
              reg_rs         <= 1'b1;
              reg_d[WIDTH-1] <= fill_q[0];
            end else begin
              reg_ls   <= 1'b1;
              reg_d[0] <= fill_q[0];
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, is the data width of the controlled bidirectional shift register.
REQ-002 Parameter CNT_W, default 3, is the width of the shift-count field.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 clr  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  controller can accept a command.
REQ-007 cmd_op  input  2  opcode: 00 LOAD, 01 SHL, 10 SHR, 11 CLEAR.
REQ-008 cmd_cnt  input  CNT_W  shift count for SHL/SHR; ignored otherwise.
REQ-009 cmd_data  input  WIDTH  load value (LOAD) or serial fill bits, LSB first (SHL/SHR).
REQ-010 reg_clr_n  output  1  synchronous active-low clear strobe to the register.
REQ-011 reg_load  output  1  parallel-load strobe to the register.
REQ-012 reg_ls  output  1  left-shift strobe; the register takes reg_d[0] as its new LSB.
REQ-013 reg_rs  output  1  right-shift strobe; the register takes reg_d[WIDTH-1] as its new MSB.
REQ-014 reg_d  output  WIDTH  data and serial-in bits to the register.
REQ-015 busy  output  1  a command is executing.
REQ-016 done  output  1  one-cycle pulse on command completion.

Function
REQ-017 A handshake occurs on a rising edge where cmd_valid=1 and cmd_ready=1. At that edge the controller captures cmd_op, cmd_cnt and cmd_data, so later input changes have no effect on the command.
REQ-018 cmd_ready is 1 only in state IDLE with clr=1; cmd_valid held while cmd_ready=0 is not accepted.
REQ-019 FSM states:
- IDLE: on handshake, go to LOAD, CLEAR or SHIFT by opcode. For SHL/SHR with cmd_cnt=0, go to FIN.
- LOAD, CLEAR: one cycle, then FIN.
- SHIFT: stays for exactly cmd_cnt cycles, then FIN.
- FIN: one cycle, then IDLE.
REQ-020 All reg_* outputs, busy and done are registered with no combinational input-to-output paths; cmd_ready decodes from state and clr only.
REQ-021 LOAD: reg_load=1 and reg_d=captured data for exactly one cycle, the cycle after the handshake.
REQ-022 CLEAR: reg_clr_n=0 for exactly one cycle, the cycle after the handshake.
REQ-023 SHL with count n: reg_ls=1 for n consecutive cycles starting the cycle after the handshake. In shift cycle k (k=0..n-1), reg_d[0] = captured data bit k if k<WIDTH, else 0.
REQ-024 SHR with count n: identical to SHL, except reg_rs=1 and the fill bit is driven on reg_d[WIDTH-1].
REQ-025 Unused reg_d bits are 0 in every cycle; reg_d=0 whenever no strobe is active.
REQ-026 At most one of reg_load, reg_ls, reg_rs and (not reg_clr_n) is active in any cycle.
REQ-027 Latency: for a handshake at edge T with m control cycles (m=1 for LOAD/CLEAR, m=n for shifts), done=1 during the single cycle after the last control cycle. For m=0, done=1 the cycle after T.
REQ-028 busy=1 from the cycle after the handshake through the done cycle inclusive; busy=0 otherwise.
REQ-029 The shift counter is CNT_W wide and decrements to zero without wrap-around; the maximum count is 2^CNT_W-1.
REQ-030 Back-to-back commands: the earliest next handshake is the cycle after done, so there are no idle strobe gaps beyond FIN.

Reset
REQ-031 While clr=0: state=IDLE, reg_load=reg_ls=reg_rs=0, reg_clr_n=1, reg_d=0, busy=0, done=0, cmd_ready=0, counter=0.
REQ-032 Reset asserted mid-command aborts it immediately and asynchronously: no further strobes occur and no done pulse is produced.
REQ-033 The first handshake is possible on the first rising edge after clr deasserts.

Structure
REQ-034 A shared package/include, shift_seq_pkg, holds the opcode encodings (OP_LOAD, OP_SHL, OP_SHR, OP_CLEAR) and the FSM state encodings.
REQ-035 One sub-module, shift_seq_counter, is a CNT_W-bit loadable down-counter with a zero flag; the FSM and output registers stay in shift_seq_ctrl.

Verification
REQ-036 Bench instantiates shift_seq_ctrl connected to a 4-bit bidirectional shift register model and checks both the strobes and the register contents.
REQ-037 LOAD data=4'b1010 -> reg_load=1 with reg_d=1010 for one cycle; done two cycles after the handshake; register=1010.
REQ-038 After a load of 0000, SHL cnt=3 data=4'b0101 -> reg_ls high for 3 cycles with reg_d[0]=1,0,1; register=0101; done at handshake+4.
REQ-039 After a load of 1111, SHR cnt=6 data=4'b0011 -> reg_rs high for 6 cycles with fill bits 1,1,0,0,0,0; register=0000.
REQ-040 SHL cnt=0 -> no strobes; done at handshake+1; busy high for exactly one cycle.
REQ-041 clr pulled low during cycle 2 of SHR cnt=5 -> strobes drop immediately, no done pulse; after release, cmd_ready=1 and a CLEAR command gives reg_clr_n=0 for one cycle.
REQ-042 cmd_valid held high for 3 back-to-back LOADs -> handshakes exactly 3 cycles apart; the strobe mutual-exclusion assertion never fires.
